// File: rtl/dsp_drain_pkg.sv
// Shared types and helpers for the systolic column drain block.
// With DSP_DRAIN_SAT_EN defined, a saturating-add helper is also provided.
package dsp_drain_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, EMIT} drain_state_e;

  localparam int LANE_DW = 8;

  typedef struct packed {
    logic signed [LANE_DW:0] lane1;
    logic signed [LANE_DW:0] lane0;
  } lanes_t;

  // The upper lane was packed on top of a sign-extended lower lane, so a
  // negative lane0 borrowed one from lane1; adding w[7] back undoes that.
  function automatic lanes_t unpack_lanes(input logic [2*LANE_DW-1:0] w);
    lanes_t l;
    l.lane0 = {w[LANE_DW-1], w[LANE_DW-1:0]};
    l.lane1 = {w[2*LANE_DW-1], w[2*LANE_DW-1:LANE_DW]}
            + {{LANE_DW{1'b0}}, w[LANE_DW-1]};
    return l;
  endfunction

`ifdef DSP_DRAIN_SAT_EN
  typedef struct packed {
    logic [63:0] sum;
    logic        clamp;
  } sat_res_t;

  // Operands arrive sign-extended to 64 bits; the result is clamped to dw bits.
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int dw);
    logic signed [64:0] s;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    sat_res_t r;
    s  = {a[63], a} + {b[63], b};
    hi = (65'sd1 <<< (dw - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (dw - 1));
    r.sum   = s[63:0];
    r.clamp = 1'b0;
    if (s > hi) begin
      r.sum   = hi[63:0];
      r.clamp = 1'b1;
    end else if (s < lo) begin
      r.sum   = lo[63:0];
      r.clamp = 1'b1;
    end
    return r;
  endfunction
`endif

endpackage

// File: rtl/dsp_col_drain_psum_lane_unpack.sv
// One row of the accumulator bank: unpacks a psum word and overwrites or
// accumulates both lanes. DSP_DRAIN_SAT_EN selects saturating accumulation.
module psum_lane_unpack
  import dsp_drain_pkg::*;
#(
  parameter int VER_BUS_DW = 16,
  parameter int ACC_DW     = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [VER_BUS_DW-1:0] word,
  input  logic                  load,
  input  logic                  first,
`ifdef DSP_DRAIN_SAT_EN
  output logic                  clamp,
`endif
  output logic [2*ACC_DW-1:0]   acc
);

  lanes_t            lanes;
  logic [ACC_DW-1:0] ext0;
  logic [ACC_DW-1:0] ext1;
  logic [ACC_DW-1:0] acc0_reg;
  logic [ACC_DW-1:0] acc1_reg;
  logic [ACC_DW-1:0] acc0_next;
  logic [ACC_DW-1:0] acc1_next;
`ifdef DSP_DRAIN_SAT_EN
  sat_res_t          res0;
  sat_res_t          res1;
`endif

  assign lanes = unpack_lanes(word[2*LANE_DW-1:0]);
  assign ext0  = {{(ACC_DW-LANE_DW-1){lanes.lane0[LANE_DW]}}, lanes.lane0};
  assign ext1  = {{(ACC_DW-LANE_DW-1){lanes.lane1[LANE_DW]}}, lanes.lane1};

  always_comb begin
    acc0_next = acc0_reg;
    acc1_next = acc1_reg;
`ifdef DSP_DRAIN_SAT_EN
    clamp = 1'b0;
    res0  = sat_add({{(64-ACC_DW){acc0_reg[ACC_DW-1]}}, acc0_reg},
                    {{(64-ACC_DW){ext0[ACC_DW-1]}}, ext0}, ACC_DW);
    res1  = sat_add({{(64-ACC_DW){acc1_reg[ACC_DW-1]}}, acc1_reg},
                    {{(64-ACC_DW){ext1[ACC_DW-1]}}, ext1}, ACC_DW);
`endif
    if (load) begin
      if (first) begin
        acc0_next = ext0;
        acc1_next = ext1;
      end else begin
`ifdef DSP_DRAIN_SAT_EN
        acc0_next = res0.sum[ACC_DW-1:0];
        acc1_next = res1.sum[ACC_DW-1:0];
        clamp     = res0.clamp | res1.clamp;
`else
        acc0_next = acc0_reg + ext0;
        acc1_next = acc1_reg + ext1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc0_reg <= '0;
      acc1_reg <= '0;
    end else begin
      acc0_reg <= acc0_next;
      acc1_reg <= acc1_next;
    end
  end

  assign acc = {acc1_reg, acc0_reg};

endmodule

// File: rtl/dsp_col_drain.sv
// Drains one systolic column's packed psum chain, accumulates per-row lanes
// across K-tiles and streams results. DSP_DRAIN_SAT_EN adds saturation + sat_flag.
module dsp_col_drain
  import dsp_drain_pkg::*;
#(
  parameter int VER_BUS_DW  = 16,
  parameter int ROWS        = 8,
  parameter int ACC_DW      = 24,
  parameter int CAPTURE_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    drain_req,
  input  logic                    drain_last,
  output logic                    drain_ack,
  output logic                    busy,
  output logic                    psum_sel,
  input  logic [VER_BUS_DW-1:0]   col_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*ACC_DW-1:0]     out_data,
  output logic [$clog2(ROWS)-1:0] out_row,
`ifdef DSP_DRAIN_SAT_EN
  output logic                    sat_flag,
`endif
  output logic                    out_last
);

  localparam int ROW_W  = $clog2(ROWS);
  localparam int WAIT_W = (CAPTURE_LAT > 1) ? $clog2(CAPTURE_LAT) : 1;
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(CAPTURE_LAT - 1);

  drain_state_e      state_reg, state_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [ROW_W-1:0]  row_reg, row_next;
  logic              last_flag_reg, last_flag_next;
  logic              first_flag_reg, first_flag_next;
  logic              drain_ack_reg, drain_ack_next;
  logic [2*ACC_DW-1:0] acc_bank [ROWS];
`ifdef DSP_DRAIN_SAT_EN
  logic [ROWS-1:0]   clamp_vec;
  logic              sat_flag_reg, sat_flag_next;
`endif

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    psum_lane_unpack #(
      .VER_BUS_DW (VER_BUS_DW),
      .ACC_DW     (ACC_DW)
    ) u_row (
      .clk   (clk),
      .rst_n (rst_n),
      .word  (col_in),
      .load  ((state_reg == CAPTURE) && (row_reg == ROW_W'(gi))),
      .first (first_flag_reg),
`ifdef DSP_DRAIN_SAT_EN
      .clamp (clamp_vec[gi]),
`endif
      .acc   (acc_bank[gi])
    );
  end

  always_comb begin
    state_next      = state_reg;
    wait_cnt_next   = wait_cnt_reg;
    row_next        = row_reg;
    last_flag_next  = last_flag_reg;
    first_flag_next = first_flag_reg;
    drain_ack_next  = 1'b0;
    busy            = (state_reg != IDLE);
    psum_sel        = (state_reg == WAIT) || (state_reg == CAPTURE);
    out_valid       = (state_reg == EMIT);
    out_data        = '0;
    out_row         = '0;
    out_last        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (drain_req) begin
          last_flag_next = drain_last;
          wait_cnt_next  = '0;
          state_next     = WAIT;
        end
      end
      WAIT: begin
        wait_cnt_next = wait_cnt_reg + 1'b1;
        if (wait_cnt_reg == WAIT_END) begin
          row_next   = '0;
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (row_reg == LAST_ROW) begin
          first_flag_next = 1'b0;
          row_next        = '0;
          if (last_flag_reg) begin
            state_next = EMIT;
          end else begin
            drain_ack_next = 1'b1;
            state_next     = IDLE;
          end
        end else begin
          row_next = row_reg + 1'b1;
        end
      end
      EMIT: begin
        out_data = acc_bank[row_reg];
        out_row  = row_reg;
        out_last = (row_reg == LAST_ROW);
        if (out_ready) begin
          if (row_reg == LAST_ROW) begin
            drain_ack_next  = 1'b1;
            first_flag_next = 1'b1;
            row_next        = '0;
            state_next      = IDLE;
          end else begin
            row_next = row_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

`ifdef DSP_DRAIN_SAT_EN
    // Sticky across tiles; a new output block starts clean.
    sat_flag_next = sat_flag_reg | (|clamp_vec);
    if (first_flag_next && !first_flag_reg) begin
      sat_flag_next = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      wait_cnt_reg   <= '0;
      row_reg        <= '0;
      last_flag_reg  <= 1'b0;
      first_flag_reg <= 1'b1;
      drain_ack_reg  <= 1'b0;
`ifdef DSP_DRAIN_SAT_EN
      sat_flag_reg   <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      wait_cnt_reg   <= wait_cnt_next;
      row_reg        <= row_next;
      last_flag_reg  <= last_flag_next;
      first_flag_reg <= first_flag_next;
      drain_ack_reg  <= drain_ack_next;
`ifdef DSP_DRAIN_SAT_EN
      sat_flag_reg   <= sat_flag_next;
`endif
    end
  end

  assign drain_ack = drain_ack_reg;
`ifdef DSP_DRAIN_SAT_EN
  assign sat_flag = sat_flag_reg;
`endif

endmodule

// File: tb/tb_dsp_col_drain.sv
// Scoreboard bench for dsp_col_drain (ROWS=4); a second 10-bit instance
// shares the stimulus to exercise wrap or DSP_DRAIN_SAT_EN saturation.
module tb_dsp_col_drain;

  localparam int ROWS        = 4;
  localparam int CAPTURE_LAT = 2;
  localparam int ACC_DW      = 24;
  localparam int SAT_DW      = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic drain_req = 1'b0;
  logic drain_last = 1'b0;
  logic out_ready = 1'b1;
  logic [15:0] col_in = 16'h0000;

  logic drain_ack, busy, psum_sel, out_valid, out_last;
  logic [2*ACC_DW-1:0] out_data;
  logic [1:0] out_row;
  logic s_drain_ack, s_busy, s_psum_sel, s_out_valid, s_out_last;
  logic [2*SAT_DW-1:0] s_out_data;
  logic [1:0] s_out_row;
`ifdef DSP_DRAIN_SAT_EN
  logic sat_flag, s_sat_flag;
`endif

  always #5 clk = ~clk;

  dsp_col_drain #(.VER_BUS_DW(16), .ROWS(ROWS), .ACC_DW(ACC_DW), .CAPTURE_LAT(CAPTURE_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .drain_req(drain_req), .drain_last(drain_last),
    .drain_ack(drain_ack), .busy(busy), .psum_sel(psum_sel), .col_in(col_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
`ifdef DSP_DRAIN_SAT_EN
    .sat_flag(sat_flag),
`endif
    .out_last(out_last)
  );

  dsp_col_drain #(.VER_BUS_DW(16), .ROWS(ROWS), .ACC_DW(SAT_DW), .CAPTURE_LAT(CAPTURE_LAT)) dut_s (
    .clk(clk), .rst_n(rst_n), .drain_req(drain_req), .drain_last(drain_last),
    .drain_ack(s_drain_ack), .busy(s_busy), .psum_sel(s_psum_sel), .col_in(col_in),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_row(s_out_row),
`ifdef DSP_DRAIN_SAT_EN
    .sat_flag(s_sat_flag),
`endif
    .out_last(s_out_last)
  );

  typedef struct {
    logic [2*ACC_DW-1:0] data;
    int                  row;
    logic                last;
  } beat_t;

  beat_t sb[$];
  int    m0[ROWS];
  int    m1[ROWS];
  bit    m_first = 1'b1;
  int    n_checks = 0;
  int    n_fail = 0;

  function automatic int lane0_of(input logic [15:0] w);
    int v = int'(w[7:0]);
    if (v > 127) v -= 256;
    return v;
  endfunction

  function automatic int lane1_of(input logic [15:0] w);
    int v = int'(w[15:8]);
    if (v > 127) v -= 256;
    return v + int'(w[7]);
  endfunction

  task automatic run_drain(input logic [16*ROWS-1:0] words, input bit last);
    logic [15:0] w;
    beat_t b;
    drain_req  = 1'b1;
    drain_last = last;
    @(posedge clk); #1;
    drain_req  = 1'b0;
    drain_last = 1'b0;
    n_checks++;
    if (psum_sel !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_start: psum_sel=%b busy=%b required 1/1", psum_sel, busy);
    end
    repeat (CAPTURE_LAT) @(posedge clk);
    #1;
    for (int r = 0; r < ROWS; r++) begin
      w = words[r*16 +: 16];
      col_in = w;
      n_checks++;
      if (psum_sel !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL capture_row%0d: psum_sel=%b out_valid=%b required 1/0", r, psum_sel, out_valid);
      end
      if (m_first) begin
        m0[r] = lane0_of(w);
        m1[r] = lane1_of(w);
      end else begin
        m0[r] += lane0_of(w);
        m1[r] += lane1_of(w);
      end
      @(posedge clk); #1;
    end
    col_in  = 16'hBAD0;
    m_first = 1'b0;
    n_checks++;
    if (psum_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL sel_fall: psum_sel=%b required 0", psum_sel);
    end
    if (last) begin
      for (int r = 0; r < ROWS; r++) begin
        b.data = {ACC_DW'(m1[r]), ACC_DW'(m0[r])};
        b.row  = r;
        b.last = (r == ROWS - 1);
        sb.push_back(b);
      end
      m_first = 1'b1;
      n_checks++;
      if (out_valid !== 1'b1 || drain_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL emit_latency: out_valid=%b drain_ack=%b required 1/0", out_valid, drain_ack);
      end
    end else begin
      n_checks++;
      if (out_valid !== 1'b0 || drain_ack !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL tile_ack: out_valid=%b drain_ack=%b busy=%b required 0/1/0", out_valid, drain_ack, busy);
      end
    end
  endtask

  task automatic collect(input int stall_beat, input int stall_n, input bit chk_sat,
                         input logic [SAT_DW-1:0] exp_s0);
    int beats = 0;
    int cyc = 0;
    int stall_left = stall_n;
    int lasts = 0;
    beat_t e;
    while (beats < ROWS && cyc < 40) begin
      n_checks++;
      if (out_valid !== 1'b1 || sb.size() == 0) begin
        n_fail++;
        $display("FAIL emit_valid: out_valid=%b queued=%0d required out_valid=1 with queued beat", out_valid, sb.size());
      end else begin
        e = sb[0];
        out_ready = !(beats == stall_beat && stall_left > 0);
        n_checks++;
        if (out_data !== e.data || out_row !== 2'(e.row) || out_last !== e.last) begin
          n_fail++;
          $display("FAIL emit_beat%0d: data=%h row=%0d last=%b required data=%h row=%0d last=%b",
                   beats, out_data, out_row, out_last, e.data, e.row, e.last);
        end
        if (chk_sat) begin
          n_checks++;
          if (s_out_valid !== 1'b1 || s_out_data !== {{SAT_DW{1'b0}}, exp_s0}) begin
            n_fail++;
            $display("FAIL narrow_acc: valid=%b data=%h required valid=1 data=%h", s_out_valid, s_out_data, {{SAT_DW{1'b0}}, exp_s0});
          end
`ifdef DSP_DRAIN_SAT_EN
          n_checks++;
          if (s_sat_flag !== 1'b1 || sat_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_flag: narrow=%b wide=%b required 1/0", s_sat_flag, sat_flag);
          end
`endif
        end
        if (out_ready) begin
          if (out_last) lasts++;
          e = sb.pop_front();
          beats++;
        end else begin
          stall_left--;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b1;
    n_checks++;
    if (beats != ROWS || lasts != 1) begin
      n_fail++;
      $display("FAIL emit_count: beats=%0d out_last_beats=%0d required %0d/1", beats, lasts, ROWS);
    end
    n_checks++;
    if (drain_ack !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL emit_done: drain_ack=%b out_valid=%b busy=%b required 1/0/0", drain_ack, out_valid, busy);
    end
`ifdef DSP_DRAIN_SAT_EN
    n_checks++;
    if (s_sat_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_clear: sat_flag=%b required 0", s_sat_flag);
    end
`endif
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (drain_ack !== 1'b0 || busy !== 1'b0 || psum_sel !== 1'b0 || out_valid !== 1'b0 ||
        out_data !== '0 || out_row !== 2'd0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%b busy=%b sel=%b valid=%b data=%h row=%0d last=%b required all 0",
               drain_ack, busy, psum_sel, out_valid, out_data, out_row, out_last);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_tile();
    run_drain({ROWS{16'h0305}}, 1'b1);
    collect(-1, 0, 1'b0, '0);
  endtask

  task automatic test_borrow();
    run_drain({16'h8080, 16'hFFFF, 16'h0080, 16'h02FF}, 1'b1);
    collect(-1, 0, 1'b0, '0);
  endtask

  task automatic test_two_tiles();
    run_drain({ROWS{16'h0102}}, 1'b0);
    run_drain({ROWS{16'h0304}}, 1'b1);
    collect(-1, 0, 1'b0, '0);
  endtask

  task automatic test_backpressure();
    run_drain({16'h0004, 16'h0003, 16'h0002, 16'h0001}, 1'b1);
    collect(1, 5, 1'b0, '0);
  endtask

  task automatic test_back_to_back();
    run_drain({16'h7F01, 16'h1020, 16'hF00F, 16'h0A0B}, 1'b1);
    collect(-1, 0, 1'b0, '0);
    run_drain({16'h0011, 16'h0022, 16'h0033, 16'h0044}, 1'b1);
    collect(-1, 0, 1'b0, '0);
  endtask

  task automatic test_saturation();
    logic [SAT_DW-1:0] exp_s0;
`ifdef DSP_DRAIN_SAT_EN
    exp_s0 = SAT_DW'(511);
`else
    exp_s0 = SAT_DW'(-8);
`endif
    for (int t = 0; t < 8; t++) begin
      run_drain({ROWS{16'h007F}}, t == 7);
    end
    collect(-1, 0, 1'b1, exp_s0);
  endtask

  task automatic test_reset_mid_emit();
    run_drain({ROWS{16'h0203}}, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_row !== 2'd2) begin
      n_fail++;
      $display("FAIL pre_abort: out_valid=%b out_row=%0d required 1/2", out_valid, out_row);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0 || psum_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: out_valid=%b busy=%b data=%h psum_sel=%b required 0/0/0/0", out_valid, busy, out_data, psum_sel);
    end
    sb.delete();
    m_first = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_drain({ROWS{16'h0101}}, 1'b1);
    collect(-1, 0, 1'b0, '0);
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_borrow();
    test_two_tiles();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_reset_mid_emit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
